load_store_unit: RTL and testbench

Multi-cycle load/store sequencer between the execute stage and the word-addressed data memory. It converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-only memory accesses. Sub-word stores use a read-modify-write sequence. Sub-word loads are lane-selected and sign- or zero-extended. The core is stalled through `busy_o` until `done_o`.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/load_formatter.sv | 54 +++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access-legality check applied when a request is accepted.
package lsu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE,
        ST_DONE
    } lsu_state_t;

    // Stores exist only as SB/SH/SW, so the unsigned codes are illegal for writes.
    function automatic logic access_ok(input logic write, input logic [2:0] funct3,
                                       input logic [1:0] byte_offset);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !write;
            F3_H:    ok = !byte_offset[0];
            F3_HU:   ok = !write && !byte_offset[0];
            F3_W:    ok = (byte_offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational lane select and sign/zero extension of a memory word, plus the
// byte-lane mask of the addressed lane (used by the store merge path).
module load_formatter
    import lsu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_offset,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            lane_mask
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  byte_mask;
    logic [3:0]  half_mask;

    assign byte_sel  = word[{byte_offset, 3'b000} +: 8];
    assign half_sel  = byte_offset[1] ? word[31:16] : word[15:0];
    assign byte_mask = 4'b0001 << byte_offset;
    assign half_mask = byte_offset[1] ? 4'b1100 : 4'b0011;

    always_comb begin
        result    = '0;
        lane_mask = '0;
        case (funct3)
            F3_B: begin
                result    = {{24{byte_sel[7]}}, byte_sel};
                lane_mask = byte_mask;
            end
            F3_BU: begin
                result    = {24'd0, byte_sel};
                lane_mask = byte_mask;
            end
            F3_H: begin
                result    = {{16{half_sel[15]}}, half_sel};
                lane_mask = half_mask;
            end
            F3_HU: begin
                result    = {16'd0, half_sel};
                lane_mask = half_mask;
            end
            F3_W: begin
                result    = word;
                lane_mask = 4'b1111;
            end
            default: begin
                result    = '0;
                lane_mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer: word-only memory accesses, read-modify-write
// for sub-word stores, lane-selected and extended sub-word loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = lsu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

    lsu_state_t            state_reg;
    logic                  write_reg;
    logic [2:0]            funct3_reg;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] store_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] load_data_reg;
    logic [DATA_WIDTH-1:0] merge_reg;

    logic [DATA_WIDTH-1:0] fmt_result;
    logic [3:0]            lane_mask;
    logic [DATA_WIDTH-1:0] store_lanes;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  is_sub_store;

    load_formatter u_formatter (
        .word        (mem_read_data_i),
        .funct3      (funct3_reg),
        .byte_offset (addr_reg[1:0]),
        .result      (fmt_result),
        .lane_mask   (lane_mask)
    );

    assign is_sub_store = write_reg && (funct3_reg != F3_W);

    // Replicate the store byte/halfword across every lane; the mask picks the target.
    assign store_lanes = (funct3_reg == F3_B) ? {4{store_reg[7:0]}} : {2{store_reg[15:0]}};

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
        assign merged_word[gi*8 +: 8] = lane_mask[gi] ? store_lanes[gi*8 +: 8]
                                                      : merge_reg[gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            write_reg     <= 1'b0;
            funct3_reg    <= '0;
            addr_reg      <= '0;
            store_reg     <= '0;
            err_reg       <= 1'b0;
            load_data_reg <= '0;
            merge_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        write_reg  <= req_write_i;
                        funct3_reg <= funct3_i;
                        addr_reg   <= address_i;
                        store_reg  <= store_data_i;
                        if (access_ok(req_write_i, funct3_i, address_i[1:0])) begin
                            err_reg   <= 1'b0;
                            state_reg <= ST_ACCESS;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_reg) begin
                        load_data_reg <= fmt_result;
                        state_reg     <= ST_DONE;
                    end else if (is_sub_store) begin
                        merge_reg <= mem_read_data_i;
                        state_reg <= ST_MERGE;
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_MERGE: state_reg <= ST_DONE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode directly from state so an asynchronous reset kills them at once.
    always_comb begin
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_address_o    = '0;
        mem_write_data_o = '0;
        case (state_reg)
            ST_ACCESS: begin
                mem_address_o = {addr_reg[DATA_WIDTH-1:2], 2'b00};
                if (!write_reg || is_sub_store) begin
                    mem_read_o = 1'b1;
                end else begin
                    mem_write_o      = 1'b1;
                    mem_write_data_o = store_reg;
                end
            end
            ST_MERGE: begin
                mem_address_o    = {addr_reg[DATA_WIDTH-1:2], 2'b00};
                mem_write_o      = 1'b1;
                mem_write_data_o = merged_word;
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = (state_reg == ST_DONE);
    assign error_o     = done_o && err_reg;
    assign load_data_o = load_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected results,
// a negedge monitor pops and compares on every done_o pulse.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] address_i;
    logic [31:0] store_data_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] load_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_write_data_o;
    logic [31:0] mem_read_data_i;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_write_i      (req_write_i),
        .funct3_i         (funct3_i),
        .address_i        (address_i),
        .store_data_i     (store_data_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .load_data_o      (load_data_o),
        .mem_read_o       (mem_read_o),
        .mem_write_o      (mem_write_o),
        .mem_address_o    (mem_address_o),
        .mem_write_data_o (mem_write_data_o),
        .mem_read_data_i  (mem_read_data_i)
    );

    // Word memory: 0x10 and 0x18 hold 0x8899AABB, 0x1C holds 0x01234567.
    logic [31:0] mem [0:15] = '{0, 0, 0, 0, 32'h8899AABB, 0, 32'h8899AABB, 32'h01234567,
                                0, 0, 0, 0, 0, 0, 0, 0};

    assign mem_read_data_i = mem_read_o ? mem[mem_address_o[5:2]] : 32'd0;

    always @(posedge clk) begin
        if (mem_write_o) mem[mem_address_o[5:2]] <= mem_write_data_o;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          rd;
        int          wr;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_load = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: counts strobes per transaction and scores every completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (mem_read_o && mem_write_o) chk("both_strobes", 32'd1, 32'd0);
                if (mem_read_o) rd_cnt++;
                if (mem_write_o) wr_cnt++;
                if (done_o) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("error_o", 32'(error_o), 32'(e.err));
                        chk("load_data_o", load_data_o, e.data);
                        chk("latency", 32'(cycle - e.acc + 1), 32'(e.lat));
                        chk("read_pulses", 32'(rd_cnt), 32'(e.rd));
                        chk("write_pulses", 32'(wr_cnt), 32'(e.wr));
                        $display("txn done: err=%0b load_data=%h lat=%0d rd=%0d wr=%0d",
                                 error_o, load_data_o, cycle - e.acc + 1, rd_cnt, wr_cnt);
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic err, input logic [31:0] ldata,
                         input int lat, input int rd, input int wrc);
        exp_t e;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_write_i  = wr;
        funct3_i     = f3;
        address_i    = addr;
        store_data_i = sd;
        e.err = err; e.data = ldata; e.lat = lat; e.rd = rd; e.wr = wrc; e.acc = cycle + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        last_load = exp;
        issue(1'b0, f3, addr, 32'd0, 1'b0, exp, 2, 1, 0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd);
        if (f3 == 3'd2) issue(1'b1, f3, addr, sd, 1'b0, last_load, 2, 0, 1);
        else            issue(1'b1, f3, addr, sd, 1'b0, last_load, 3, 1, 1);
    endtask

    task automatic bad(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        issue(wr, f3, addr, 32'hFFFF_FFFF, 1'b1, last_load, 1, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done_err"}, {30'd0, done_o, error_o}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, mem_read_o, mem_write_o}, 32'd0);
        chk({tag, "_load_data"}, load_data_o, 32'd0);
        chk({tag, "_mem_addr"}, mem_address_o, 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        req_valid_i  = 1'b0;
        req_write_i  = 1'b0;
        funct3_i     = 3'd0;
        address_i    = 32'd0;
        store_data_i = 32'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        load(3'd0, 32'h11, 32'hFFFF_FFAA);          // LB
        load(3'd4, 32'h11, 32'h0000_00AA);          // LBU
        load(3'd1, 32'h12, 32'hFFFF_8899);          // LH
        load(3'd5, 32'h12, 32'h0000_8899);          // LHU
        store(3'd0, 32'h1B, 32'h1234_5677);         // SB lane 3 of 0x18
        load(3'd2, 32'h18, 32'h7799_AABB);
        store(3'd1, 32'h10, 32'h0000_CAFE);         // SH low half of 0x10
        load(3'd2, 32'h10, 32'h8899_CAFE);
        load(3'd1, 32'h10, 32'hFFFF_CAFE);
        store(3'd2, 32'h14, 32'hDEAD_BEEF);         // SW
        load(3'd2, 32'h14, 32'hDEAD_BEEF);
        bad(1'b0, 3'd2, 32'h12);                    // misaligned LW
        bad(1'b1, 3'd1, 32'h11);                    // misaligned SH
        bad(1'b0, 3'd3, 32'h10);                    // illegal funct3
        load(3'd0, 32'h1C, 32'h0000_0067);
        load(3'd0, 32'h1F, 32'h0000_0001);
        load(3'd5, 32'h1E, 32'h0000_0123);

        // Abort an SB to 0x19 with reset in its MERGE cycle.
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_write_i  = 1'b1;
        funct3_i     = 3'd0;
        address_i    = 32'h19;
        store_data_i = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #1 chk("merge_write_before_reset", 32'(mem_write_o), 32'd1);
        #1 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 chk("mem_after_reset", mem[6], 32'h7799_AABB);
        @(negedge clk);
        reset = 1'b1;
        last_load = 32'd0;
        load(3'd2, 32'h18, 32'h7799_AABB);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
